ps2_key_event_rx: RTL and testbench

PS/2 keyboard front end (scan code set 2). Deserialises device-to-host frames and tracks the F0 (break) and E0 (extended) prefixes. Translates supported scancodes into the 8-bit key-event format and emits one event per key action as a single-cycle strobe. Sits directly upstream of the keyboard register block: o_KeyEvent and o_Enable drive its w_KeyEvent and w_Enable inputs on the same clock.

---
 rtl/ps2_key_event_rx.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_rx.sv
// Purpose : PS/2 set-2 keyboard receiver; turns device-to-host frames into 8-bit key events {up, keycode}.
// Latency : o_Enable pulses one w_Clk cycle after the filtered falling edge that samples the stop bit.
// Backpressure: none; the downstream register block must take every o_Enable strobe (at most one per frame).
// Ports   : w_Clk/w_Rst_n system clock and async active-low reset; w_Ps2Clk/w_Ps2Data raw async PS/2 lines;
//           o_KeyEvent key event (bit7 up/down, bits6:0 keycode); o_Enable single-cycle event strobe.
module ps2_key_event_rx #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       w_Clk,
   input  logic       w_Rst_n,
   input  logic       w_Ps2Clk,
   input  logic       w_Ps2Data,
   output logic [7:0] o_KeyEvent,
   output logic       o_Enable
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Synchronisers reset to the idle-high line level so reset release cannot fake an edge.
   logic          clk_s1_q, clk_s2_q;
   logic          dat_s1_q, dat_s2_q;

   logic          filt_clk_q, filt_clk_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          sample;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          brk_q, brk_d;
   logic          ext_q, ext_d;
   logic [7:0]    key_q, key_d;
   logic          en_q, en_d;
   logic [7:0]    map_res;

   // Returns {hit, keycode[6:0]}; hit=0 for unmapped scancodes.
   function automatic logic [7:0] map_key(input logic [7:0] sc);
      logic [7:0] r;
      r = 8'h00;
      case (sc)
         8'h1C: r = 8'h84;  8'h32: r = 8'h85;  8'h21: r = 8'h86;  8'h23: r = 8'h87;
         8'h24: r = 8'h88;  8'h2B: r = 8'h89;  8'h34: r = 8'h8A;  8'h33: r = 8'h8B;
         8'h43: r = 8'h8C;  8'h3B: r = 8'h8D;  8'h42: r = 8'h8E;  8'h4B: r = 8'h8F;
         8'h3A: r = 8'h90;  8'h31: r = 8'h91;  8'h44: r = 8'h92;  8'h4D: r = 8'h93;
         8'h15: r = 8'h94;  8'h2D: r = 8'h95;  8'h1B: r = 8'h96;  8'h2C: r = 8'h97;
         8'h3C: r = 8'h98;  8'h2A: r = 8'h99;  8'h1D: r = 8'h9A;  8'h22: r = 8'h9B;
         8'h35: r = 8'h9C;  8'h1A: r = 8'h9D;
         8'h16: r = 8'h9E;  8'h1E: r = 8'h9F;  8'h26: r = 8'hA0;  8'h25: r = 8'hA1;
         8'h2E: r = 8'hA2;  8'h36: r = 8'hA3;  8'h3D: r = 8'hA4;  8'h3E: r = 8'hA5;
         8'h46: r = 8'hA6;  8'h45: r = 8'hA7;
         8'h12: r = 8'hF2;  8'h59: r = 8'hF3;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   assign map_res = map_key(shift_q);

   // Glitch filter: the filtered clock follows the synchronised clock only after
   // FILTER_LEN consecutive samples disagree with it; any agreeing sample restarts the count.
   always_comb begin
      filt_clk_d = filt_clk_q;
      filt_cnt_d = '0;
      if (clk_s2_q != filt_clk_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_clk_d = clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   assign sample = filt_clk_q & ~filt_clk_d;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      brk_d     = brk_q;
      ext_d     = ext_q;
      key_d     = key_q;
      en_d      = 1'b0;

      if (state_q == IDLE || sample) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (sample && !dat_s2_q) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (sample) begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (sample) begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               state_d = IDLE;
               if ((^{shift_q, par_q}) && dat_s2_q) begin
                  if (shift_q == 8'hF0) begin
                     brk_d = 1'b1;
                  end else if (shift_q == 8'hE0) begin
                     ext_d = 1'b1;
                  end else begin
                     brk_d = 1'b0;
                     ext_d = 1'b0;
                     // Extended keys are not supported: the byte after E0 is swallowed.
                     if (!ext_q && map_res[7]) begin
                        en_d  = 1'b1;
                        key_d = {brk_q, map_res[6:0]};
                     end
                  end
               end else begin
                  brk_d = 1'b0;
                  ext_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A stalled frame is abandoned; prefixes already received stay pending.
      if (state_q != IDLE && !sample && tmo_q == TW'(TIMEOUT_CYCLES)) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge w_Clk or negedge w_Rst_n) begin
      if (!w_Rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge w_Clk or negedge w_Rst_n) begin
      if (!w_Rst_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_clk_q <= 1'b1;
         filt_cnt_q <= '0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         par_q      <= 1'b0;
         tmo_q      <= '0;
         brk_q      <= 1'b0;
         ext_q      <= 1'b0;
         key_q      <= 8'h00;
         en_q       <= 1'b0;
      end else begin
         clk_s1_q   <= w_Ps2Clk;
         clk_s2_q   <= clk_s1_q;
         dat_s1_q   <= w_Ps2Data;
         dat_s2_q   <= dat_s1_q;
         filt_clk_q <= filt_clk_d;
         filt_cnt_q <= filt_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tmo_q      <= tmo_d;
         brk_q      <= brk_d;
         ext_q      <= ext_d;
         key_q      <= key_d;
         en_q       <= en_d;
      end
   end

   assign o_KeyEvent = key_q;
   assign o_Enable   = en_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Purpose : self-checking bench for ps2_key_event_rx; a scoreboard queue holds expected key events.
// Latency : stop-bit falling edge to strobe checked as 2 sync stages + FILTER_LEN filter samples.
// Backpressure: n/a; every strobe is popped and compared as it appears.
module tb_ps2_key_event_rx;

   localparam int FILTER_LEN     = 4;
   localparam int TIMEOUT_CYCLES = 5000;
   localparam int HALF           = 20;

   logic       w_Clk;
   logic       w_Rst_n;
   logic       w_Ps2Clk;
   logic       w_Ps2Data;
   logic [7:0] o_KeyEvent;
   logic       o_Enable;

   int         checks;
   int         errors;
   int         cyc;
   int         stop_cyc;
   int         en_cyc;
   int         en_cnt;
   logic       prev_en;
   logic [7:0] exp_q[$];

   ps2_key_event_rx #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .w_Clk     (w_Clk),
      .w_Rst_n   (w_Rst_n),
      .w_Ps2Clk  (w_Ps2Clk),
      .w_Ps2Data (w_Ps2Data),
      .o_KeyEvent(o_KeyEvent),
      .o_Enable  (o_Enable)
   );

   initial w_Clk = 1'b0;
   always #5 w_Clk = ~w_Clk;

   initial cyc = 0;
   always @(posedge w_Clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every strobe must have a pending expectation and match it.
   initial prev_en = 1'b0;
   always @(negedge w_Clk) begin
      if (w_Rst_n && o_Enable) begin
         en_cnt++;
         en_cyc = cyc;
         check_eq("single_cycle_strobe", {31'd0, prev_en}, 0);
         check_eq("strobe_expected", {31'd0, exp_q.size() != 0}, 1);
         if (exp_q.size() != 0) begin
            check_eq("key_event", {24'd0, o_KeyEvent}, {24'd0, exp_q.pop_front()});
         end
      end
      prev_en = o_Enable;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge w_Clk);
      #1;
   endtask

   // One PS/2 bit: data settles, clock low for HALF cycles, then high for HALF cycles.
   // With glitch set, three 1-cycle low pulses are injected into the high phase.
   task automatic ps2_bit(input logic b, input bit glitch, input bit last);
      tick(1);
      w_Ps2Data = b;
      tick(5);
      w_Ps2Clk = 1'b0;
      if (last) stop_cyc = cyc;
      tick(HALF);
      w_Ps2Clk = 1'b1;
      if (glitch) begin
         for (int g = 0; g < 3; g++) begin
            tick(3);
            w_Ps2Clk = 1'b0;
            tick(1);
            w_Ps2Clk = 1'b1;
         end
      end
      tick(HALF);
   endtask

   // mode: 0 good, 1 bad parity, 2 bad stop, 3 good with clock glitches. nbits < 11 stalls mid-frame.
   task automatic send_frame(input logic [7:0] d, input int mode, input int nbits);
      logic [10:0] fr;
      logic        par;
      par = ~(^d);
      if (mode == 1) par = ~par;
      fr = {(mode == 2) ? 1'b0 : 1'b1, par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_bit(fr[i], mode == 3, i == 10);
      end
      w_Ps2Data = 1'b1;
      w_Ps2Clk  = 1'b1;
      tick(30);
   endtask

   task automatic phase_end(input string tag, input int n_exp);
      tick(30);
      check_eq({tag, "_drain"}, exp_q.size(), 0);
      check_eq({tag, "_count"}, en_cnt, n_exp);
      en_cnt = 0;
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      en_cnt    = 0;
      stop_cyc  = 0;
      en_cyc    = 0;
      w_Rst_n   = 1'b0;
      w_Ps2Clk  = 1'b1;
      w_Ps2Data = 1'b1;
      tick(5);
      check_eq("reset_key", {24'd0, o_KeyEvent}, 0);
      check_eq("reset_en", {31'd0, o_Enable}, 0);
      w_Rst_n = 1'b1;
      tick(5);

      // Single make code, strobe latency and hold.
      exp_q.push_back(8'h04);
      send_frame(8'h1C, 0, 11);
      phase_end("make_a", 1);
      check_eq("latency", en_cyc - stop_cyc, 2 + FILTER_LEN);
      check_eq("hold_key", {24'd0, o_KeyEvent}, 8'h04);
      check_eq("en_low_after", {31'd0, o_Enable}, 0);

      // Break codes.
      send_frame(8'hF0, 0, 11);
      exp_q.push_back(8'h84);
      send_frame(8'h1C, 0, 11);
      send_frame(8'hF0, 0, 11);
      exp_q.push_back(8'hF3);
      send_frame(8'h59, 0, 11);
      phase_end("break", 2);

      // Digits, shift, unmapped code.
      exp_q.push_back(8'h27);
      send_frame(8'h45, 0, 11);
      exp_q.push_back(8'h72);
      send_frame(8'h12, 0, 11);
      send_frame(8'h76, 0, 11);
      exp_q.push_back(8'h1D);
      send_frame(8'h1A, 0, 11);
      phase_end("map", 3);

      // Extended keys dropped, flags cleared afterwards.
      send_frame(8'hE0, 0, 11);
      send_frame(8'h75, 0, 11);
      send_frame(8'hE0, 0, 11);
      send_frame(8'hF0, 0, 11);
      send_frame(8'h75, 0, 11);
      exp_q.push_back(8'h04);
      send_frame(8'h1C, 0, 11);
      phase_end("ext", 1);

      // Frame errors.
      send_frame(8'h1C, 1, 11);
      send_frame(8'hF0, 0, 11);
      send_frame(8'h1C, 2, 11);
      exp_q.push_back(8'h04);
      send_frame(8'h1C, 0, 11);
      phase_end("frame_err", 1);

      // Glitches: while idle with data low, then throughout a good frame.
      w_Ps2Data = 1'b0;
      for (int g = 0; g < 4; g++) begin
         tick(5);
         w_Ps2Clk = 1'b0;
         tick(1);
         w_Ps2Clk = 1'b1;
      end
      tick(5);
      w_Ps2Data = 1'b1;
      tick(10);
      exp_q.push_back(8'h04);
      send_frame(8'h1C, 3, 11);
      phase_end("glitch", 1);

      // Timeout discards the partial frame.
      send_frame(8'h1C, 0, 5);
      tick(TIMEOUT_CYCLES + 20);
      exp_q.push_back(8'h04);
      send_frame(8'h1C, 0, 11);
      phase_end("timeout", 1);

      // Timeout keeps a pending break prefix.
      send_frame(8'hF0, 0, 11);
      send_frame(8'h32, 0, 5);
      tick(TIMEOUT_CYCLES + 20);
      exp_q.push_back(8'h84);
      send_frame(8'h1C, 0, 11);
      phase_end("timeout_brk", 1);

      // Asynchronous reset mid-frame.
      send_frame(8'h59, 0, 5);
      w_Rst_n = 1'b0;
      #1;
      check_eq("rst_mid_key", {24'd0, o_KeyEvent}, 0);
      check_eq("rst_mid_en", {31'd0, o_Enable}, 0);
      tick(3);
      w_Rst_n = 1'b1;
      tick(5);
      exp_q.push_back(8'h04);
      send_frame(8'h1C, 0, 11);
      phase_end("after_rst", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
